// File: rtl/scan_pkg.sv
// Shared types and sizing helpers for the scan pattern controller.
package scan_pkg;

  localparam int unsigned CHAIN_LEN_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CAPTURE,
    S_UNLOAD,
    S_FIN
  } state_e;

  // Mismatch counter must hold CHAIN_LEN itself without wrapping.
  function automatic int unsigned cnt_w_f(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/scan_shreg.sv
// Parallel-load shift register presenting its MSB; shifts toward the MSB.
module scan_shreg #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] din_i,
  output logic         msb_o
);

  logic [W-1:0] data_q;

  // Load has priority over shift; reset clears the contents.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= din_i;
    end else if (shift_i) begin
      data_q <= {data_q[W-2:0], 1'b0};
    end
  end

  assign msb_o = data_q[W-1];

endmodule

// File: rtl/scan_ctrl.sv
// Scan chain controller: loads a pattern, pulses capture, unloads and
// counts mismatches against expected data.
module scan_ctrl
  import scan_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = CHAIN_LEN_DEF,
  parameter int unsigned CNT_W     = cnt_w_f(CHAIN_LEN)
) (
  input  logic                 CP,
  input  logic                 CD,
  input  logic                 START,
  input  logic [CHAIN_LEN-1:0] PAT_IN,
  input  logic [CHAIN_LEN-1:0] EXP_IN,
  input  logic                 SO,
  output logic                 SE,
  output logic                 SI,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 PASS,
  output logic [CNT_W-1:0]     ERR_CNT
);

  localparam int unsigned  BW   = $clog2(CHAIN_LEN);
  localparam logic [BW-1:0] LAST = BW'(CHAIN_LEN - 1);

  state_e            state_q, state_d;
  logic [BW-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic              se_q, se_d;
  logic              si_q, si_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pat_load, pat_shift, pat_msb;
  logic              exp_load, exp_shift, exp_msb;

  // Bit CHAIN_LEN-1 goes straight into si_q at START, so the pattern register
  // is loaded pre-shifted and its MSB is always the next bit to drive.
  scan_shreg #(.W(CHAIN_LEN)) u_pat (
    .clk_i   (CP),
    .rst_i   (CD),
    .load_i  (pat_load),
    .shift_i (pat_shift),
    .din_i   ({PAT_IN[CHAIN_LEN-2:0], 1'b0}),
    .msb_o   (pat_msb)
  );

  scan_shreg #(.W(CHAIN_LEN)) u_exp (
    .clk_i   (CP),
    .rst_i   (CD),
    .load_i  (exp_load),
    .shift_i (exp_shift),
    .din_i   (EXP_IN),
    .msb_o   (exp_msb)
  );

  // State, counters and registered outputs.
  always_ff @(posedge CP) begin
    if (CD) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= '0;
      se_q    <= 1'b0;
      si_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      se_q    <= se_d;
      si_q    <= si_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state; outputs are decoded for the state being entered.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    se_d      = 1'b0;
    si_d      = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    pat_load  = 1'b0;
    pat_shift = 1'b0;
    exp_load  = 1'b0;
    exp_shift = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d  = S_LOAD;
          pat_load = 1'b1;
          exp_load = 1'b1;
          cnt_d    = '0;
          err_d    = '0;
          se_d     = 1'b1;
          si_d     = PAT_IN[CHAIN_LEN-1];
          busy_d   = 1'b1;
        end
      end
      S_LOAD: begin
        busy_d = 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_CAPTURE;
          cnt_d   = '0;
        end else begin
          cnt_d     = cnt_q + BW'(1);
          se_d      = 1'b1;
          si_d      = pat_msb;
          pat_shift = 1'b1;
        end
      end
      S_CAPTURE: begin
        state_d = S_UNLOAD;
        busy_d  = 1'b1;
        se_d    = 1'b1;
      end
      S_UNLOAD: begin
        exp_shift = 1'b1;
        if (SO != exp_msb) begin
          err_d = err_q + CNT_W'(1);
        end
        if (cnt_q == LAST) begin
          state_d = S_FIN;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d  = cnt_q + BW'(1);
          busy_d = 1'b1;
          se_d   = 1'b1;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign SE      = se_q;
  assign SI      = si_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign PASS    = done_q & (err_q == '0);
  assign ERR_CNT = err_q;

endmodule

// File: tb/tb_scan_ctrl.sv
// Bench for scan_ctrl driving a 4-flop scan chain model.
module tb_scan_ctrl;

  localparam int unsigned N = 4;

  logic         CP = 1'b0;
  logic         CD;
  logic         START;
  logic [N-1:0] PAT_IN;
  logic [N-1:0] EXP_IN;
  logic         SO;
  logic         SE;
  logic         SI;
  logic         BUSY;
  logic         DONE;
  logic         PASS;
  logic [2:0]   ERR_CNT;

  logic [N-1:0] chain_q;
  logic [N-1:0] chain_d_vec;

  int checks   = 0;
  int failures = 0;

  always #5 CP = ~CP;

  scan_ctrl #(.CHAIN_LEN(N)) dut (
    .CP      (CP),
    .CD      (CD),
    .START   (START),
    .PAT_IN  (PAT_IN),
    .EXP_IN  (EXP_IN),
    .SO      (SO),
    .SE      (SE),
    .SI      (SI),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .PASS    (PASS),
    .ERR_CNT (ERR_CNT)
  );

  // Chain of async-reset scan flops: flop 0 is the head, SE selects SI over D.
  always @(posedge CP or posedge CD) begin
    if (CD) chain_q <= '0;
    else if (SE) chain_q <= {chain_q[N-2:0], SI};
    else chain_q <= chain_d_vec;
  end
  assign SO = chain_q[N-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full operation; extra_a/extra_b are cycles (after START) with a stray START.
  task automatic run_op(input string tag, input logic [N-1:0] pat, input logic [N-1:0] expv,
                        input logic [N-1:0] dvec, input int extra_a, input int extra_b);
    int         done_cnt;
    int         done_cyc;
    logic       pass_at;
    logic [2:0] err_at;
    logic       busy_ok;
    logic       se_ok;
    logic       si_ok;
    logic [N-1:0] chain_after;
    int         exp_err;
    done_cnt = 0; done_cyc = -1; pass_at = 1'b0; err_at = '0;
    busy_ok = 1'b1; se_ok = 1'b1; si_ok = 1'b1; chain_after = '0;
    // Captured values are the D inputs, so mismatches are the differing bits.
    exp_err = $countones(dvec ^ expv);
    chain_d_vec = dvec;
    @(posedge CP); #1;
    PAT_IN = pat; EXP_IN = expv; START = 1'b1;
    @(posedge CP); #1;
    START = 1'b0; PAT_IN = N'($urandom); EXP_IN = N'($urandom);
    for (int k = 1; k <= 14; k++) begin
      if (DONE === 1'b1) begin
        done_cnt++; done_cyc = k; pass_at = PASS; err_at = ERR_CNT;
      end
      if (BUSY !== (k <= 2*N+1)) busy_ok = 1'b0;
      if (SE !== ((k >= 1 && k <= N) || (k >= N+2 && k <= 2*N+1))) se_ok = 1'b0;
      if (!(k >= 1 && k <= N) && SI !== 1'b0) si_ok = 1'b0;
      if (k == N+1) chain_after = chain_q;
      START = (k == extra_a || k == extra_b);
      @(posedge CP); #1;
    end
    START = 1'b0;
    check({tag, "_chain_loaded"}, chain_after, pat);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_done_cycle"}, done_cyc, 2*N+2);
    check({tag, "_pass"}, pass_at, exp_err == 0);
    check({tag, "_err_cnt"}, err_at, exp_err);
    check({tag, "_busy_window"}, busy_ok, 1'b1);
    check({tag, "_se_window"}, se_ok, 1'b1);
    check({tag, "_si_idle_zero"}, si_ok, 1'b1);
    check({tag, "_err_cnt_held"}, ERR_CNT, exp_err);
    check({tag, "_idle_after"}, {BUSY, DONE, SE}, 3'b000);
  endtask

  initial begin
    int done_seen;
    int busy_seen;
    CD = 1'b1; START = 1'b0; PAT_IN = '0; EXP_IN = '0; chain_d_vec = 4'b0110;
    repeat (3) @(posedge CP);
    #1;
    check("reset_outputs", {SE, SI, BUSY, DONE, PASS}, 5'b00000);
    check("reset_err_cnt", ERR_CNT, 0);
    CD = 1'b0;

    run_op("pass_1010", 4'b1010, 4'b0110, 4'b0110, -1, -1);
    run_op("one_err",   4'b1010, 4'b0111, 4'b0110, -1, -1);
    run_op("all_err",   4'b1010, 4'b1001, 4'b0110, -1, -1);
    run_op("stray_start", 4'b0011, 4'b0110, 4'b0110, 3, 10);

    // Reset during LOAD cycle 2 aborts the operation without DONE.
    chain_d_vec = 4'b0110;
    @(posedge CP); #1;
    PAT_IN = 4'b1010; EXP_IN = 4'b0000; START = 1'b1;
    @(posedge CP); #1;
    START = 1'b0;
    @(posedge CP); #1;
    CD = 1'b1;
    @(posedge CP); #1;
    CD = 1'b0;
    check("abort_outputs", {SE, BUSY, DONE}, 3'b000);
    check("abort_err_cnt", ERR_CNT, 0);
    done_seen = 0; busy_seen = 0;
    for (int k = 0; k < 14; k++) begin
      if (DONE === 1'b1) done_seen++;
      if (BUSY === 1'b1) busy_seen++;
      @(posedge CP); #1;
    end
    check("abort_no_done", done_seen, 0);
    check("abort_no_busy", busy_seen, 0);
    run_op("after_abort", 4'b1010, 4'b0110, 4'b0110, -1, -1);

    // Reset wins over a simultaneous START.
    @(posedge CP); #1;
    PAT_IN = 4'b1111; EXP_IN = 4'b0000; START = 1'b1; CD = 1'b1;
    @(posedge CP); #1;
    START = 1'b0; CD = 1'b0;
    done_seen = 0; busy_seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (DONE === 1'b1) done_seen++;
      if (BUSY === 1'b1 || SE === 1'b1) busy_seen++;
      @(posedge CP); #1;
    end
    check("cd_start_no_activity", busy_seen, 0);
    check("cd_start_no_done", done_seen, 0);

    // Randomised patterns, expected data and capture values.
    for (int r = 0; r < 8; r++) begin
      run_op("rand", N'($urandom), N'($urandom), N'($urandom), -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
